mpu_reg_access_arbiter: RTL

Access arbiter on the matrix register file side of the MPU load/store handshake. It receives the dispatcher load request, the collector write request and the three matrix addresses from the MPU controller. It also takes a single host load/store port. It grants disp_ready and collector_ready only when the addressed registers are free of conflicting host access, and it locks those registers until the multiplication's writeback completes.

---
 rtl/mpu_reg_access_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mpu_reg_access_arbiter.sv
// mpu_reg_access_arbiter
// Arbitrates the matrix register file between the MPU load/store path
// (dispatcher load + collector writeback) and a single host load/store port.
// The MPU side read-locks its two source registers while the dispatcher loads
// and reserves the destination until the collector writeback has finished.
// Host accesses that would collide with those locks are held off, and a granted
// host access in turn holds off an MPU dispatch that would collide with it.
//
// Handshake semantics (all request inputs are levels, all grants registered):
//   - A request is sampled on a rising clk edge; if no conflict exists at that
//     edge, its grant output is high from the following cycle onward.
//   - A requester keeps its request high until granted and for the whole
//     access; dropping the request (sampled at an edge) releases the grant on
//     the following cycle. The MPU destination stays reserved past the
//     dispatcher release until the collector write is seen and has ended.
//   - Grants are decoded from registered state only; no request input reaches
//     a grant output combinationally.
module mpu_reg_access_arbiter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_disp_req_in,
    input  logic              reg_collector_req_in,
    input  logic [ADDR_W-1:0] reg_src_addr_0_in,
    input  logic [ADDR_W-1:0] reg_src_addr_1_in,
    input  logic [ADDR_W-1:0] reg_dest_addr_in,
    output logic              disp_ready_out,
    output logic              collector_ready_out,
    input  logic              host_req_in,
    input  logic              host_wr_in,
    input  logic [ADDR_W-1:0] host_addr_in,
    output logic              host_grant_out,
    output logic              mpu_busy_out,
    output logic              protocol_err_out,
    output logic [1:0]        dbg_mpu_state_out,
    output logic              dbg_host_state_out
);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_READ  = 2'd1,
        M_WRITE = 2'd2
    } mpu_state_t;

    typedef enum logic {
        H_IDLE  = 1'b0,
        H_GRANT = 1'b1
    } host_state_t;

    mpu_state_t        r_mpu_state;
    mpu_state_t        w_mpu_next;
    host_state_t       r_host_state;
    host_state_t       w_host_next;

    logic [ADDR_W-1:0] r_src0;
    logic [ADDR_W-1:0] r_src1;
    logic [ADDR_W-1:0] r_dest;
    logic              r_write_seen;
    logic              w_write_seen_next;
    logic [ADDR_W-1:0] r_host_addr;
    logic              r_host_wr;
    logic              r_disp_req_d;
    logic              r_protocol_err;
    logic              w_protocol_err_next;

    logic              w_mpu_blocked;
    logic              w_mpu_start;
    logic              w_host_blocked;
    logic              w_host_start;

    // A write touching any of the three MPU registers collides; a read only
    // collides with the destination, since sources may be shared by readers.
    function automatic logic access_conflict(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] s0,
        input logic [ADDR_W-1:0] s1,
        input logic [ADDR_W-1:0] d
    );
        if (wr) begin
            return (addr == s0) || (addr == s1) || (addr == d);
        end
        return (addr == d);
    endfunction

    // Conflict detection from registered locks plus same-cycle new requests.
    always_comb begin
        w_mpu_blocked  = 1'b0;
        w_mpu_start    = 1'b0;
        w_host_blocked = 1'b0;
        w_host_start   = 1'b0;

        // A host access already granted holds off a colliding dispatch.
        if (r_host_state == H_GRANT) begin
            w_mpu_blocked = access_conflict(r_host_wr, r_host_addr,
                                            reg_src_addr_0_in, reg_src_addr_1_in,
                                            reg_dest_addr_in);
        end
        w_mpu_start = (r_mpu_state == M_IDLE) && reg_disp_req_in && !w_mpu_blocked;

        // Existing MPU locks: sources + dest in M_READ, dest only in M_WRITE.
        if (r_mpu_state == M_READ) begin
            w_host_blocked = access_conflict(host_wr_in, host_addr_in,
                                             r_src0, r_src1, r_dest);
        end else if (r_mpu_state == M_WRITE) begin
            w_host_blocked = (host_addr_in == r_dest);
        end

        // A dispatch starting this same edge wins over a colliding host request.
        if (w_mpu_start && access_conflict(host_wr_in, host_addr_in,
                                           reg_src_addr_0_in, reg_src_addr_1_in,
                                           reg_dest_addr_in)) begin
            w_host_blocked = 1'b1;
        end
        w_host_start = (r_host_state == H_IDLE) && host_req_in && !w_host_blocked;
    end

    // MPU next-state, write_seen tracking and protocol error detection.
    always_comb begin
        w_mpu_next          = r_mpu_state;
        w_write_seen_next   = r_write_seen;
        w_protocol_err_next = 1'b0;
        case (r_mpu_state)
            M_IDLE: begin
                if (reg_collector_req_in) begin
                    w_protocol_err_next = 1'b1;
                end
                if (w_mpu_start) begin
                    w_mpu_next        = M_READ;
                    w_write_seen_next = 1'b0;
                end
            end
            M_READ: begin
                if (reg_collector_req_in) begin
                    w_write_seen_next = 1'b1;
                end
                if (!reg_disp_req_in) begin
                    w_mpu_next = M_WRITE;
                end
            end
            M_WRITE: begin
                // A new dispatch cannot start until the writeback is over.
                if (reg_disp_req_in && !r_disp_req_d) begin
                    w_protocol_err_next = 1'b1;
                end
                if (r_write_seen && !reg_collector_req_in) begin
                    w_mpu_next = M_IDLE;
                end else if (reg_collector_req_in) begin
                    w_write_seen_next = 1'b1;
                end
            end
            default: begin
                w_mpu_next = M_IDLE;
            end
        endcase
    end

    // Host next-state: grant when conflict-free, release when request drops.
    always_comb begin
        w_host_next = r_host_state;
        case (r_host_state)
            H_IDLE: begin
                if (w_host_start) begin
                    w_host_next = H_GRANT;
                end
            end
            H_GRANT: begin
                if (!host_req_in) begin
                    w_host_next = H_IDLE;
                end
            end
            default: begin
                w_host_next = H_IDLE;
            end
        endcase
    end

    // State registers; reset drops every lock and grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mpu_state    <= M_IDLE;
            r_host_state   <= H_IDLE;
            r_write_seen   <= 1'b0;
            r_disp_req_d   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_mpu_state    <= w_mpu_next;
            r_host_state   <= w_host_next;
            r_write_seen   <= w_write_seen_next;
            r_disp_req_d   <= reg_disp_req_in;
            r_protocol_err <= w_protocol_err_next;
        end
    end

    // Address latches captured on grant; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src0      <= '0;
            r_src1      <= '0;
            r_dest      <= '0;
            r_host_addr <= '0;
            r_host_wr   <= 1'b0;
        end else begin
            if (w_mpu_start) begin
                r_src0 <= reg_src_addr_0_in;
                r_src1 <= reg_src_addr_1_in;
                r_dest <= reg_dest_addr_in;
            end
            if (w_host_start) begin
                r_host_addr <= host_addr_in;
                r_host_wr   <= host_wr_in;
            end
        end
    end

    assign disp_ready_out      = (r_mpu_state == M_READ);
    assign collector_ready_out = (r_mpu_state != M_IDLE);
    assign mpu_busy_out        = (r_mpu_state != M_IDLE);
    assign host_grant_out      = (r_host_state == H_GRANT);
    assign protocol_err_out    = r_protocol_err;
    assign dbg_mpu_state_out   = r_mpu_state;
    assign dbg_host_state_out  = r_host_state;

endmodule
